// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - parametrised UART receiver with glitch rejection, parity/framing checks and receive FIFO
module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_frame_err,
   output logic                 o_parity_err,
   output logic                 o_rx_valid,
   input  logic                 i_rx_ready,
   output logic                 o_overrun
);
   localparam int CNT_W  = $clog2(CLKS_PER_BIT);
   localparam int IDX_W  = $clog2(DATA_BITS + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int WORD_W = DATA_BITS + 2;

   localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
   localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   logic                 sync0_q, s1_q, prev_q;
   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
   logic                 stop_q, stop_d;
   logic                 push_q, push_d;
   logic                 fall;

   logic [WORD_W-1:0]    mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PTR_W:0]       count_q, count_d;
   logic                 full, pop, push_ok;
   logic [WORD_W-1:0]    head;

   assign fall = prev_q & ~s1_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      idx_d   = idx_q;
      data_d  = data_q;
      ferr_d  = ferr_q;
      perr_d  = perr_q;
      stop_d  = stop_q;
      push_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (fall) begin
               state_d = S_START;
               data_d  = '0;
               ferr_d  = 1'b0;
               perr_d  = 1'b0;
            end
         end
         S_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d = '0;
               idx_d = '0;
               state_d = s1_q ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            // LSB arrives first, so after DATA_BITS right shifts it sits at bit 0
            if (cnt_q == FULL_M1) begin
               cnt_d  = '0;
               data_d = {s1_q, data_q[DATA_BITS-1:1]};
               idx_d  = idx_q + IDX_W'(1);
               if (idx_q == LAST_IDX) begin
                  stop_d  = 1'b0;
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (cnt_q == FULL_M1) begin
               cnt_d   = '0;
               perr_d  = (PARITY == 1) ? ~(^data_q ^ s1_q) : (^data_q ^ s1_q);
               stop_d  = 1'b0;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (cnt_q == FULL_M1) begin
               cnt_d = '0;
               if (!s1_q) ferr_d = 1'b1;
               if (stop_q == 1'(STOP_BITS - 1)) begin
                  state_d = S_IDLE;
                  push_d  = 1'b1;
               end else begin
                  stop_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign full    = (count_q == DEPTH_C);
   assign pop     = o_rx_valid & i_rx_ready;
   assign push_ok = push_q & (~full | pop);

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_ok) wptr_d = wptr_q + PTR_W'(1);
      if (pop)     rptr_d = rptr_q + PTR_W'(1);
      case ({push_ok, pop})
         2'b10:   count_d = count_q + (PTR_W + 1)'(1);
         2'b01:   count_d = count_q - (PTR_W + 1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync0_q <= 1'b1;
         s1_q    <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
         stop_q  <= 1'b0;
         push_q  <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         sync0_q <= rx;
         s1_q    <= sync0_q;
         prev_q  <= s1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         ferr_q  <= ferr_d;
         perr_q  <= perr_d;
         stop_q  <= stop_d;
         push_q  <= push_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wptr_q] <= {perr_q, ferr_q, data_q};
   end

   // Outputs read as zero while empty so reset leaves no stale word visible
   assign head         = mem_q[rptr_q];
   assign o_rx_valid   = (count_q != '0);
   assign o_rx_data    = o_rx_valid ? head[DATA_BITS-1:0] : '0;
   assign o_frame_err  = o_rx_valid & head[DATA_BITS];
   assign o_parity_err = o_rx_valid & head[DATA_BITS+1];
   assign o_overrun    = push_q & full & ~pop;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo: 8N1, glitch, even parity, two stop bits, overrun, reset
module tb_uart_rx_fifo;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b1;
   logic rx_a = 1'b1, rx_p = 1'b1, rx_s = 1'b1;
   logic rdy_a = 1'b0, rdy_p = 1'b0, rdy_s = 1'b0;
   logic [7:0] d_a, d_p, d_s;
   logic fe_a, fe_p, fe_s, pe_a, pe_p, pe_s;
   logic v_a, v_p, v_s, ov_a, ov_p, ov_s;

   int n_cmp = 0;
   int n_bad = 0;
   logic [9:0] exp_a[$], exp_p[$], exp_s[$];

   uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .rx(rx_a), .o_rx_data(d_a), .o_frame_err(fe_a),
      .o_parity_err(pe_a), .o_rx_valid(v_a), .i_rx_ready(rdy_a), .o_overrun(ov_a));
   uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_p (
      .clk_i(clk), .rst_ni(rst_n), .rx(rx_p), .o_rx_data(d_p), .o_frame_err(fe_p),
      .o_parity_err(pe_p), .o_rx_valid(v_p), .i_rx_ready(rdy_p), .o_overrun(ov_p));
   uart_rx_fifo #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_s (
      .clk_i(clk), .rst_ni(rst_n), .rx(rx_s), .o_rx_data(d_s), .o_frame_err(fe_s),
      .o_parity_err(pe_s), .o_rx_valid(v_s), .i_rx_ready(rdy_s), .o_overrun(ov_s));

   function automatic logic get_valid(input int w);
      case (w)
         0: return v_a;
         1: return v_p;
         default: return v_s;
      endcase
   endfunction

   function automatic logic get_ovr(input int w);
      case (w)
         0: return ov_a;
         1: return ov_p;
         default: return ov_s;
      endcase
   endfunction

   function automatic logic [9:0] get_word(input int w);
      case (w)
         0: return {pe_a, fe_a, d_a};
         1: return {pe_p, fe_p, d_p};
         default: return {pe_s, fe_s, d_s};
      endcase
   endfunction

   task automatic set_rx(input int w, input logic v);
      case (w)
         0: rx_a = v;
         1: rx_p = v;
         default: rx_s = v;
      endcase
   endtask

   task automatic set_rdy(input int w, input logic v);
      case (w)
         0: rdy_a = v;
         1: rdy_p = v;
         default: rdy_s = v;
      endcase
   endtask

   task automatic push_exp(input int w, input logic [9:0] e);
      case (w)
         0: exp_a.push_back(e);
         1: exp_p.push_back(e);
         default: exp_s.push_back(e);
      endcase
   endtask

   task automatic pop_exp(input int w, output logic [9:0] e);
      e = 10'h3ff;
      case (w)
         0: if (exp_a.size() > 0) e = exp_a.pop_front();
         1: if (exp_p.size() > 0) e = exp_p.pop_front();
         default: if (exp_s.size() > 0) e = exp_s.pop_front();
      endcase
   endtask

   task automatic drive_bit(input int w, input logic v);
      @(posedge clk);
      #1 set_rx(w, v);
      repeat (15) @(posedge clk);
   endtask

   // Expected word is {parity_err, frame_err, data}; parity here is even (only dut_p has parity)
   task automatic send_frame(input int w, input logic [7:0] d, input bit has_par, input logic pbit,
                             input int nstop, input logic [1:0] stops, input bit expect_push);
      logic perr, ferr;
      perr = has_par ? ((^d) ^ pbit) : 1'b0;
      ferr = ~stops[0] | ((nstop == 2) & ~stops[1]);
      if (expect_push) push_exp(w, {perr, ferr, d});
      drive_bit(w, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(w, d[i]);
      if (has_par) drive_bit(w, pbit);
      for (int i = 0; i < nstop; i++) drive_bit(w, stops[i]);
   endtask

   task automatic wait_valid(input int w, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (get_valid(w) === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic pop_one(input int w);
      set_rdy(w, 1'b1);
      @(posedge clk);
      #1 set_rdy(w, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int w = 0; w < 3; w++) begin
         n_cmp++;
         if (get_valid(w) !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid[%0d]: got %b want 0", w, get_valid(w));
         end
         n_cmp++;
         if (get_ovr(w) !== 1'b0) begin
            n_bad++; $display("FAIL reset_overrun[%0d]: got %b want 0", w, get_ovr(w));
         end
         n_cmp++;
         if (get_word(w) !== 10'h000) begin
            n_bad++; $display("FAIL reset_word[%0d]: got %h want 000", w, get_word(w));
         end
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic test_8n1();
      bit ok;
      logic [9:0] e;
      rdy_a = 1'b1;
      fork
         send_frame(0, 8'hA5, 1'b0, 1'b0, 1, 2'b11, 1'b1);
         begin
            wait_valid(0, ok);
            n_cmp++;
            if (!ok) begin
               n_bad++; $display("FAIL 8n1_timeout: got no valid want valid");
            end else begin
               pop_exp(0, e);
               n_cmp++;
               if (get_word(0) !== e) begin
                  n_bad++; $display("FAIL 8n1_word: got %h want %h", get_word(0), e);
               end
               @(negedge clk);
               n_cmp++;
               if (v_a !== 1'b0) begin
                  n_bad++; $display("FAIL 8n1_single_valid: got %b want 0", v_a);
               end
            end
         end
      join
      rdy_a = 1'b0;
   endtask

   task automatic test_glitch();
      bit ok;
      int seen;
      logic [9:0] e;
      @(posedge clk);
      #1 rx_a = 1'b0;
      repeat (4) @(posedge clk);
      #1 rx_a = 1'b1;
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (v_a !== 1'b0) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_bad++; $display("FAIL glitch_no_push: got %0d valid cycles want 0", seen);
      end
      send_frame(0, 8'h3C, 1'b0, 1'b0, 1, 2'b11, 1'b1);
      wait_valid(0, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++; $display("FAIL glitch_timeout: got no valid want valid");
      end else begin
         pop_exp(0, e);
         n_cmp++;
         if (get_word(0) !== e) begin
            n_bad++; $display("FAIL glitch_word: got %h want %h", get_word(0), e);
         end
         pop_one(0);
      end
   endtask

   task automatic test_parity();
      bit ok;
      logic [9:0] e;
      send_frame(1, 8'h07, 1'b1, 1'b0, 1, 2'b11, 1'b1);
      send_frame(1, 8'h07, 1'b1, 1'b1, 1, 2'b11, 1'b1);
      for (int k = 0; k < 2; k++) begin
         wait_valid(1, ok);
         n_cmp++;
         if (!ok) begin
            n_bad++; $display("FAIL parity_timeout[%0d]: got no valid want valid", k);
         end else begin
            pop_exp(1, e);
            n_cmp++;
            if (get_word(1) !== e) begin
               n_bad++; $display("FAIL parity_word[%0d]: got %h want %h", k, get_word(1), e);
            end
            pop_one(1);
         end
      end
   endtask

   task automatic test_stop2();
      bit ok;
      int seen;
      logic [9:0] e;
      send_frame(2, 8'h81, 1'b0, 1'b0, 2, 2'b01, 1'b1);
      wait_valid(2, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++; $display("FAIL stop2_timeout: got no valid want valid");
      end else begin
         pop_exp(2, e);
         n_cmp++;
         if (get_word(2) !== e) begin
            n_bad++; $display("FAIL stop2_word: got %h want %h", get_word(2), e);
         end
         pop_one(2);
      end
      seen = 0;
      repeat (300) begin
         @(negedge clk);
         if (v_s !== 1'b0) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
         n_bad++; $display("FAIL stop2_held_low: got %0d valid cycles want 0", seen);
      end
      rx_s = 1'b1;
      repeat (4) @(posedge clk);
   endtask

   task automatic test_back_to_back();
      bit ok, done;
      int ov;
      logic [9:0] e;
      done = 1'b0;
      ov = 0;
      fork
         begin
            for (int k = 1; k <= 5; k++) send_frame(0, 8'(k), 1'b0, 1'b0, 1, 2'b11, k < 5);
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               if (ov_a === 1'b1) ov++;
            end
         end
      join
      n_cmp++;
      if (ov != 1) begin
         n_bad++; $display("FAIL overrun_cycles: got %0d want 1", ov);
      end
      for (int k = 0; k < 4; k++) begin
         wait_valid(0, ok);
         n_cmp++;
         if (!ok) begin
            n_bad++; $display("FAIL drain_timeout[%0d]: got no valid want valid", k);
         end else begin
            pop_exp(0, e);
            n_cmp++;
            if (get_word(0) !== e) begin
               n_bad++; $display("FAIL drain_word[%0d]: got %h want %h", k, get_word(0), e);
            end
            pop_one(0);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (v_a !== 1'b0) begin
         n_bad++; $display("FAIL drain_empty: got valid %b want 0", v_a);
      end
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      logic [9:0] e;
      logic [7:0] d;
      send_frame(0, 8'h11, 1'b0, 1'b0, 1, 2'b11, 1'b1);
      send_frame(0, 8'h22, 1'b0, 1'b0, 1, 2'b11, 1'b1);
      d = 8'h33;
      drive_bit(0, 1'b0);
      for (int i = 0; i < 3; i++) drive_bit(0, d[i]);
      @(posedge clk);
      #1 rx_a = d[3];
      repeat (8) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (v_a !== 1'b1) begin
         n_bad++; $display("FAIL midrst_queued: got valid %b want 1", v_a);
      end
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (v_a !== 1'b0) begin
         n_bad++; $display("FAIL midrst_valid: got %b want 0", v_a);
      end
      exp_a.delete();
      rx_a = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (20) @(posedge clk);
      n_cmp++;
      if (v_a !== 1'b0) begin
         n_bad++; $display("FAIL midrst_no_partial: got valid %b want 0", v_a);
      end
      send_frame(0, 8'h5A, 1'b0, 1'b0, 1, 2'b11, 1'b1);
      wait_valid(0, ok);
      n_cmp++;
      if (!ok) begin
         n_bad++; $display("FAIL midrst_timeout: got no valid want valid");
      end else begin
         pop_exp(0, e);
         n_cmp++;
         if (get_word(0) !== e) begin
            n_bad++; $display("FAIL midrst_word: got %h want %h", get_word(0), e);
         end
         pop_one(0);
      end
      @(negedge clk);
      n_cmp++;
      if (v_a !== 1'b0) begin
         n_bad++; $display("FAIL midrst_empty: got valid %b want 0", v_a);
      end
   endtask

   initial begin
      test_reset();
      test_8n1();
      test_glitch();
      test_parity();
      test_stop2();
      test_back_to_back();
      test_reset_mid_frame();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
